// File: rtl/scan_boundary_ctrl_pkg.sv
// rtl/scan_boundary_ctrl_pkg.sv - command and controller state types for the boundary-scan wrapper
package scan_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } scan_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CAP,
    SHF,
    UPD,
    DONE
  } scan_state_e;

endpackage

// File: rtl/scan_boundary_ctrl_if.sv
// rtl/scan_boundary_ctrl_if.sv - command handshake bus between test master and scan controller
interface scan_boundary_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       Cmd;
  logic [CNT_W-1:0] ShiftLen;
  logic             CmdValid;
  logic             CmdReady;
  logic             Done;

  modport master (output Cmd, ShiftLen, CmdValid, input CmdReady, Done);
  modport slave  (input Cmd, ShiftLen, CmdValid, output CmdReady, Done);
endinterface

// File: rtl/scan_boundary_ctrl_cell.sv
// rtl/scan_boundary_ctrl_cell.sv - one boundary cell: chain flop plus shadow update flop
module scan_cell (
  input  logic clk,
  input  logic clr,
  input  logic capEn,
  input  logic shiftEn,
  input  logic updEn,
  input  logic capD,
  input  logic shiftD,
  output logic chainQ,
  output logic updQ
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      chainQ <= 1'b0;
    end else if (capEn) begin
      chainQ <= capD;
    end else if (shiftEn) begin
      chainQ <= shiftD;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      updQ <= 1'b0;
    end else if (updEn) begin
      updQ <= chainQ;
    end
  end

endmodule

// File: rtl/scan_boundary_ctrl.sv
// rtl/scan_boundary_ctrl.sv - boundary-scan chain around a core, sequenced by a command FSM
module scan_boundary_ctrl
  import scan_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 3,
  parameter int CNT_W   = 8
) (
  input  logic               ScanClk,
  input  logic               ScanClr,
  input  logic [NUM_IN-1:0]  FuncIn,
  output logic [NUM_IN-1:0]  CoreIn,
  input  logic [NUM_OUT-1:0] CoreOut,
  output logic [NUM_OUT-1:0] FuncOut,
  input  logic               TestEn,
  input  logic               ScanIn,
  output logic               ScanOut,
  scan_boundary_ctrl_if.slave cmdBus
);

  localparam int L = NUM_IN + NUM_OUT;

  scan_state_e      state, nextState;
  logic [CNT_W-1:0] count, nextCount;
  logic             capEn, shiftEn, updEn;
  logic [L-1:0]     chain, upd, capVec, shiftVec;

  always_ff @(posedge ScanClk or posedge ScanClr) begin
    if (ScanClr) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  always_comb begin
    nextState = state;
    nextCount = count;
    capEn     = 1'b0;
    shiftEn   = 1'b0;
    updEn     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmdBus.CmdValid) begin
          unique case (scan_cmd_e'(cmdBus.Cmd))
            NOP:     nextState = DONE;
            CAPTURE: nextState = CAP;
            UPDATE:  nextState = UPD;
            SHIFT: begin
              nextCount = cmdBus.ShiftLen;
              nextState = (cmdBus.ShiftLen == '0) ? DONE : SHF;
            end
          endcase
        end
      end
      CAP: begin
        capEn     = 1'b1;
        nextState = DONE;
      end
      SHF: begin
        // count holds the shift edges still owed, including this one
        shiftEn   = 1'b1;
        nextCount = count - CNT_W'(1);
        if (count == CNT_W'(1)) nextState = DONE;
      end
      UPD: begin
        updEn     = 1'b1;
        nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign capVec   = {CoreOut, FuncIn};
  assign shiftVec = {chain[L-2:0], ScanIn};

  for (genvar i = 0; i < L; i++) begin : gCell
    scan_cell uCell (
      .clk    (ScanClk),
      .clr    (ScanClr),
      .capEn  (capEn),
      .shiftEn(shiftEn),
      .updEn  (updEn),
      .capD   (capVec[i]),
      .shiftD (shiftVec[i]),
      .chainQ (chain[i]),
      .updQ   (upd[i])
    );
  end

  assign CoreIn          = TestEn ? upd[NUM_IN-1:0] : FuncIn;
  assign FuncOut         = TestEn ? upd[L-1:NUM_IN] : CoreOut;
  assign ScanOut         = chain[L-1];
  assign cmdBus.CmdReady = (state == IDLE);
  assign cmdBus.Done     = (state == DONE);

endmodule

// File: tb/tb_scan_boundary_ctrl.sv
// tb/tb_scan_boundary_ctrl.sv - self-checking bench for scan_boundary_ctrl
module tb_scan_boundary_ctrl;
  import scan_pkg::*;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 3;
  localparam int CNT_W   = 8;
  localparam int L       = NUM_IN + NUM_OUT;

  logic               ScanClk = 1'b0;
  logic               ScanClr;
  logic [NUM_IN-1:0]  FuncIn, CoreIn;
  logic [NUM_OUT-1:0] CoreOut, FuncOut;
  logic               TestEn, ScanIn, ScanOut;

  scan_boundary_ctrl_if #(.CNT_W(CNT_W)) cmdBus ();

  scan_boundary_ctrl #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) dut (
    .ScanClk(ScanClk),
    .ScanClr(ScanClr),
    .FuncIn (FuncIn),
    .CoreIn (CoreIn),
    .CoreOut(CoreOut),
    .FuncOut(FuncOut),
    .TestEn (TestEn),
    .ScanIn (ScanIn),
    .ScanOut(ScanOut),
    .cmdBus (cmdBus)
  );

  always #5 ScanClk = ~ScanClk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ScanClk);
    #1;
  endtask

  // Reference model: mq[0] is the bit about to leave on ScanOut, mq[L-1] the cell fed by ScanIn
  bit           mq[$];
  logic [L-1:0] mUpd;

  function automatic logic [L-1:0] modelChain();
    logic [L-1:0] v;
    for (int i = 0; i < L; i++) v[L-1-i] = mq[i];
    return v;
  endfunction

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < L; i++) mq.push_back(1'b0);
    mUpd = '0;
  endtask

  task automatic modelApply(input logic [1:0] c, input logic [7:0] n, input logic [31:0] sin,
                            output logic [31:0] expOut, output int expLat);
    logic [L-1:0] cv;
    expOut = '0;
    case (scan_cmd_e'(c))
      NOP: expLat = 1;
      CAPTURE: begin
        cv = {CoreOut, FuncIn};
        mq.delete();
        for (int i = L - 1; i >= 0; i--) mq.push_back(cv[i]);
        expLat = 2;
      end
      UPDATE: begin
        mUpd   = modelChain();
        expLat = 2;
      end
      default: begin
        for (int i = 0; i < int'(n); i++) begin
          expOut[i] = mq.pop_front();
          mq.push_back(sin[i]);
        end
        expLat = (n == 0) ? 1 : int'(n) + 1;
      end
    endcase
  endtask

  task automatic doCmd(input logic [1:0] c, input logic [7:0] n, input logic [31:0] sin,
                       output logic [31:0] sout, output int lat);
    int guard = 0;
    while (!cmdBus.CmdReady && guard < 50) begin
      tick();
      guard++;
    end
    check("cmdReady", cmdBus.CmdReady, 1);
    cmdBus.Cmd      = c;
    cmdBus.ShiftLen = n;
    cmdBus.CmdValid = 1'b1;
    tick();
    cmdBus.CmdValid = 1'b0;
    sout = '0;
    lat  = 0;
    for (int s = 1; s <= 300; s++) begin
      if (cmdBus.Done) begin
        lat = s;
        break;
      end
      if (c == 2'd2 && s <= int'(n)) begin
        sout[s-1] = ScanOut;
        ScanIn    = sin[s-1];
      end
      tick();
    end
    if (lat > 0) begin
      tick();
      check("doneOnce", cmdBus.Done, 0);
      check("readyAfterDone", cmdBus.CmdReady, 1);
    end
  endtask

  task automatic runAndCheck(input logic [1:0] c, input logic [7:0] n, input logic [31:0] sin);
    logic [31:0] expOut, sout;
    int          expLat, lat;
    logic [L-1:0] mc;
    modelApply(c, n, sin, expOut, expLat);
    doCmd(c, n, sin, sout, lat);
    check("rndLatency", lat, expLat);
    if (c == 2'd2) check("rndScanOut", sout, expOut);
    mc = modelChain();
    check("rndIdleScanOut", ScanOut, mc[L-1]);
    check("rndCoreIn", CoreIn, TestEn ? mUpd[NUM_IN-1:0] : FuncIn);
    check("rndFuncOut", FuncOut, TestEn ? mUpd[L-1:NUM_IN] : CoreOut);
  endtask

  typedef struct {
    logic [1:0]         cmd;
    logic [7:0]         len;
    logic [31:0]        sin;
    logic [NUM_IN-1:0]  funcIn;
    logic [NUM_OUT-1:0] coreOut;
    logic               testEn;
    logic [31:0]        expOut;
    logic [NUM_IN-1:0]  expCoreIn;
    logic [NUM_OUT-1:0] expFuncOut;
    int                 expLat;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] dOut, sout;
  int          dLat, lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // load, apply, degenerate commands, capture and unload
    vecs[0] = '{2'd2, 8'd7, 32'h4D, 4'h0, 3'h0, 1'b1, 32'h00, 4'h0, 3'h0, 8};
    vecs[1] = '{2'd3, 8'd0, 32'h00, 4'h0, 3'h0, 1'b1, 32'h00, 4'h9, 3'h5, 2};
    vecs[2] = '{2'd0, 8'd0, 32'h00, 4'h0, 3'h0, 1'b1, 32'h00, 4'h9, 3'h5, 1};
    vecs[3] = '{2'd2, 8'd0, 32'h00, 4'h0, 3'h0, 1'b1, 32'h00, 4'h9, 3'h5, 1};
    vecs[4] = '{2'd3, 8'd0, 32'h00, 4'h0, 3'h0, 1'b1, 32'h00, 4'h9, 3'h5, 2};
    vecs[5] = '{2'd1, 8'd0, 32'h00, 4'hA, 3'h6, 1'b1, 32'h00, 4'h9, 3'h5, 2};
    vecs[6] = '{2'd2, 8'd7, 32'h00, 4'hA, 3'h6, 1'b0, 32'h2B, 4'hA, 3'h6, 8};
    vecs[7] = '{2'd3, 8'd0, 32'h00, 4'hA, 3'h6, 1'b1, 32'h00, 4'h0, 3'h0, 2};

    ScanClr = 1'b1;
    TestEn  = 1'b1;
    FuncIn  = '0;
    CoreOut = '0;
    ScanIn  = 1'b0;
    cmdBus.Cmd      = 2'd0;
    cmdBus.ShiftLen = '0;
    cmdBus.CmdValid = 1'b0;
    #3;
    check("rstReady", cmdBus.CmdReady, 1);
    check("rstDone", cmdBus.Done, 0);
    check("rstScanOut", ScanOut, 0);
    check("rstCoreIn", CoreIn, 0);
    check("rstFuncOut", FuncOut, 0);
    tick();
    tick();
    ScanClr = 1'b0;
    modelReset();

    for (int k = 0; k < 8; k++) begin
      FuncIn  = vecs[k].funcIn;
      CoreOut = vecs[k].coreOut;
      TestEn  = vecs[k].testEn;
      modelApply(vecs[k].cmd, vecs[k].len, vecs[k].sin, dOut, dLat);
      doCmd(vecs[k].cmd, vecs[k].len, vecs[k].sin, sout, lat);
      check($sformatf("vec%0d latency", k), lat, vecs[k].expLat);
      if (vecs[k].cmd == 2'd2) check($sformatf("vec%0d scanOut", k), sout, vecs[k].expOut);
      check($sformatf("vec%0d coreIn", k), CoreIn, vecs[k].expCoreIn);
      check($sformatf("vec%0d funcOut", k), FuncOut, vecs[k].expFuncOut);
    end

    // transparency and same-cycle TestEn switching with upd all ones
    TestEn = 1'b1;
    runAndCheck(2'd2, 8'd7, 32'h7F);
    runAndCheck(2'd3, 8'd0, 32'h0);
    TestEn  = 1'b0;
    FuncIn  = 4'h5;
    CoreOut = 3'b010;
    #1;
    check("transCoreIn", CoreIn, 4'h5);
    check("transFuncOut", FuncOut, 3'b010);
    TestEn = 1'b1;
    #1;
    check("testCoreIn", CoreIn, 4'hF);
    check("testFuncOut", FuncOut, 3'b111);

    // reset mid-shift, observed without a clock edge
    cmdBus.Cmd      = 2'd2;
    cmdBus.ShiftLen = 8'd7;
    cmdBus.CmdValid = 1'b1;
    ScanIn          = 1'b1;
    tick();
    cmdBus.CmdValid = 1'b0;
    tick();
    tick();
    tick();
    check("preRstScanOut", ScanOut, 1);
    #2;
    ScanClr = 1'b1;
    #1;
    check("midRstScanOut", ScanOut, 0);
    check("midRstReady", cmdBus.CmdReady, 1);
    check("midRstDone", cmdBus.Done, 0);
    check("midRstCoreIn", CoreIn, 0);
    check("midRstFuncOut", FuncOut, 0);
    ScanClr = 1'b0;
    modelReset();
    tick();
    runAndCheck(2'd2, 8'd7, 32'h7F);

    // CmdValid held high across a SHIFT 7
    ScanIn = 1'b0;
    modelApply(2'd2, 8'd7, 32'h0, dOut, dLat);
    cmdBus.Cmd      = 2'd2;
    cmdBus.ShiftLen = 8'd7;
    cmdBus.CmdValid = 1'b1;
    tick();
    for (int s = 1; s <= 8; s++) begin
      check($sformatf("hold%0d done", s), cmdBus.Done, (s == 8));
      check($sformatf("hold%0d ready", s), cmdBus.CmdReady, 0);
      tick();
    end
    check("holdReadyBack", cmdBus.CmdReady, 1);
    cmdBus.CmdValid = 1'b0;
    tick();
    check("holdNoReaccept", cmdBus.CmdReady, 1);
    check("holdChainOut", ScanOut, 0);

    // pass-through longer than the chain, from reset
    ScanClr = 1'b1;
    #1;
    ScanClr = 1'b0;
    modelReset();
    tick();
    modelApply(2'd2, 8'd10, 32'h353, dOut, dLat);
    doCmd(2'd2, 8'd10, 32'h353, sout, lat);
    check("passScanOut", sout, 32'h180);
    check("passModel", sout, dOut);
    check("passLatency", lat, 11);

    for (int r = 0; r < 40; r++) begin
      FuncIn  = NUM_IN'($urandom);
      CoreOut = NUM_OUT'($urandom);
      TestEn  = 1'($urandom);
      runAndCheck(2'($urandom_range(0, 3)), 8'($urandom_range(0, 12)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_boundary_ctrl.md
Name: scan_boundary_ctrl

Overview:
Parametrised boundary-scan wrapper with its own command-driven controller.
- A chain of NUM_IN input cells and NUM_OUT output cells sits around a core.
- Each cell supports capture, serial shift and parallel update to a shadow register.
- A handshake-driven FSM sequences the operations, so a test master issues single commands instead of hand-driving mode pins.
- It is the generalised successor of the fixed 4-in/3-out scan wrapper and sits between chip pins and core combinational logic.

Parameters:
NUM_IN, 4, number of input boundary cells (>=1)
NUM_OUT, 3, number of output boundary cells (>=1)
CNT_W, 8, width of shift-length field and internal shift counter

Ports:
ScanClk  in  1  clock; all state updates on rising edge
ScanClr  in  1  asynchronous active-high reset
FuncIn  in  NUM_IN  functional pin inputs
CoreIn  out  NUM_IN  inputs driven into core
CoreOut  in  NUM_OUT  core results
FuncOut  out  NUM_OUT  functional pin outputs
TestEn  in  1  1 = core inputs and pins driven from update register; 0 = transparent
ScanIn  in  1  serial chain input
ScanOut  out  1  serial chain output
Cmd  in  2  0 NOP, 1 CAPTURE, 2 SHIFT, 3 UPDATE
ShiftLen  in  CNT_W  shift edges for a SHIFT command
CmdValid  in  1  command valid
CmdReady  out  1  controller idle, can accept
Done  out  1  one-cycle completion pulse

Behaviour:
- Chain length L = NUM_IN+NUM_OUT.
  - chain[NUM_IN-1:0] are the input cells; chain[L-1:NUM_IN] are the output cells.
  - ScanIn enters chain[0]; ScanOut = chain[L-1] (registered, no extra delay).
- ScanClr asserted, at any time including mid-command:
  - chain, upd and counter = 0; state = IDLE.
  - CmdReady = 1, Done = 0, ScanOut = 0, effective immediately.
- Command accept: edge where CmdValid && CmdReady; Cmd and ShiftLen are sampled at that edge. CmdValid outside IDLE is ignored and not queued.
- FSM states and transitions:
  - IDLE -> NOP: DONE.
  - IDLE -> CAPTURE: CAP.
  - IDLE -> UPDATE: UPD.
  - IDLE -> SHIFT: SHF with counter = ShiftLen, or DONE if ShiftLen == 0.
  - CAP: at the next edge, chain[i] <= FuncIn[i] and chain[NUM_IN+j] <= CoreOut[j]; -> DONE.
  - SHF: each edge, chain <= {chain[L-2:0], ScanIn} and counter decrements; -> DONE when counter == 1 at the edge. Exactly ShiftLen shift edges occur.
  - UPD: at the next edge, upd <= chain; -> DONE.
  - DONE: Done = 1 for this single cycle; -> IDLE.
- CmdReady = 1 only in IDLE.
- Latency from the accepting edge: CAPTURE/UPDATE have Done in cycle 2 and ready in cycle 3; SHIFT N has Done in cycle N+1; NOP and SHIFT 0 have Done in cycle 1.
- ShiftLen > L is legal: ScanIn data passes through and appears on ScanOut L edges later (daisy-chaining).
- Output muxes are combinational:
  - CoreIn = TestEn ? upd[NUM_IN-1:0] : FuncIn
  - FuncOut = TestEn ? upd[L-1:NUM_IN] : CoreOut
- TestEn changes take effect the same cycle and do not disturb the FSM.
- The chain and upd hold their values in all states other than CAP/SHF/UPD.

Decomposition:
- Package scan_pkg holds:
  - scan_cmd_e (NOP, CAPTURE, SHIFT, UPDATE), 2 bits
  - scan_state_e (IDLE, CAP, SHF, UPD, DONE)
- One sub-module, scan_cell: a single chain flop plus shadow update flop with capture/shift/update enables and an async clear. It is instantiated L times by generate.
- The FSM and counter live in the top level.

Test Plan:
1. Reset: issue SHIFT 7, assert ScanClr after 3 shift edges -> chain=0, upd=0, ScanOut=0, CmdReady=1, Done=0 without a clock edge; after release the next command is accepted normally.
2. Load/apply (NUM_IN=4, NUM_OUT=3): SHIFT 7 with ScanIn bits 1,0,1,1,0,0,1 (first bit first), then UPDATE, TestEn=1 -> CoreIn=4'b1001, FuncOut=3'b101; Done pulses once per command.
3. Capture/unload: FuncIn=4'hA, CoreOut=3'b110, CAPTURE then SHIFT 7 -> ScanOut before successive shift edges = 1,1,0,1,0,1,0.
4. Transparency: TestEn=0, upd=7'h7F, FuncIn=4'h5, CoreOut=3'b010 -> CoreIn=4'h5, FuncOut=3'b010 same cycle; TestEn=1 -> CoreIn=4'hF, FuncOut=3'b111.
5. Degenerate/handshake: NOP and SHIFT 0 -> Done one cycle after accept, chain unchanged; CmdValid held high during a SHIFT 7 -> no second accept until CmdReady returns, and Done occurs 8 cycles after accept.
6. Pass-through: SHIFT 10 with ScanIn 1,1,0,0,1,0,1,0,1,1 after reset -> ScanOut shows 0 for 7 edges, then 1,1,0.
